latch_id_ex: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS. Captures decoded operands and

---
 rtl/latch_id_ex_pkg.sv | 37 +++
 rtl/latch_id_ex.sv | 121 ++++++++++++
 tb/tb_latch_id_ex.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/latch_id_ex_pkg.sv
// Shared widths, control-bundle bit positions and NOP constants for the
// ID/EX pipeline register.
package latch_id_ex_pkg;

  // Default data-path widths
  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_FUNC_DEF = 6;
  localparam int NB_OP_DEF   = 2;
  localparam int NB_CNT_DEF  = 16;

  // Control bundle widths
  localparam int NB_EX_CTRL = 4;  // {RegDst, ALUSrc, ALUOp[1:0]}
  localparam int NB_M_CTRL  = 3;  // {Branch, MemRead, MemWrite}
  localparam int NB_WB_CTRL = 2;  // {RegWrite, MemtoReg}

  // EX bundle bit positions
  localparam int REGDST    = 3;
  localparam int ALUSRC    = 2;
  localparam int ALUOP_MSB = 1;
  localparam int ALUOP_LSB = 0;

  // M bundle bit positions
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  // WB bundle bit positions
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // NOP control: ALUOp=00 is a harmless add, nothing writes or branches
  localparam logic [NB_EX_CTRL-1:0] EX_NOP = '0;
  localparam logic [NB_M_CTRL-1:0]  M_NOP  = '0;
  localparam logic [NB_WB_CTRL-1:0] WB_NOP = '0;

endpackage

// File: rtl/latch_id_ex.sv
// ID/EX pipeline register: one-cycle registered hand-off of decoded operands
// and control from ID to EX, with hold, bubble/flush squash and a saturating
// count of inserted bubbles for the debug unit.
module latch_id_ex
  import latch_id_ex_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_FUNC = NB_FUNC_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_bubble,
  input  logic                  i_flush,
  input  logic [NB_DATA-1:0]    i_pc4,
  input  logic [NB_DATA-1:0]    i_rs_data,
  input  logic [NB_DATA-1:0]    i_rt_data,
  input  logic [NB_DATA-1:0]    i_imm,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  input  logic [NB_FUNC-1:0]    i_funct,
  input  logic [NB_EX_CTRL-1:0] i_ex_ctrl,
  input  logic [NB_M_CTRL-1:0]  i_m_ctrl,
  input  logic [NB_WB_CTRL-1:0] i_wb_ctrl,
  output logic [NB_DATA-1:0]    o_pc4,
  output logic [NB_DATA-1:0]    o_rs_data,
  output logic [NB_DATA-1:0]    o_rt_data,
  output logic [NB_DATA-1:0]    o_imm,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_rd,
  output logic [NB_FUNC-1:0]    o_funct,
  output logic [NB_EX_CTRL-1:0] o_ex_ctrl,
  output logic [NB_M_CTRL-1:0]  o_m_ctrl,
  output logic [NB_WB_CTRL-1:0] o_wb_ctrl,
  output logic                  o_valid,
  output logic [NB_CNT-1:0]     o_bubble_cnt
);

  // ALUOp lives in the ex bundle; its width must agree with NB_OP
  if (NB_OP != ALUOP_MSB - ALUOP_LSB + 1) begin : g_bad_op
    $error("NB_OP does not match ALUOp field width");
  end

  // Flush and bubble share one squash path; both together still count once
  logic squash;
  assign squash = i_flush | i_bubble;

  logic [NB_DATA-1:0]    pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [NB_REG-1:0]     rs_q, rt_q, rd_q;
  logic [NB_FUNC-1:0]    funct_q;
  logic [NB_EX_CTRL-1:0] ex_ctrl_q;
  logic [NB_M_CTRL-1:0]  m_ctrl_q;
  logic [NB_WB_CTRL-1:0] wb_ctrl_q;
  logic                  valid_q;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;

  // Pipeline fields: reset > hold > squash to NOP > load from ID.
  // Squash and reset write constants so unknown inputs never reach EX.
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_enable && squash)) begin
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      ex_ctrl_q <= EX_NOP;
      m_ctrl_q  <= M_NOP;
      wb_ctrl_q <= WB_NOP;
      valid_q   <= 1'b0;
    end else if (i_enable) begin
      pc4_q     <= i_pc4;
      rs_data_q <= i_rs_data;
      rt_data_q <= i_rt_data;
      imm_q     <= i_imm;
      rs_q      <= i_rs;
      rt_q      <= i_rt;
      rd_q      <= i_rd;
      funct_q   <= i_funct;
      ex_ctrl_q <= i_ex_ctrl;
      m_ctrl_q  <= i_m_ctrl;
      wb_ctrl_q <= i_wb_ctrl;
      valid_q   <= 1'b1;
    end
  end

  // Next bubble count: +1 per enabled squash edge, sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (i_enable && squash && (cnt_q != {NB_CNT{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Saturating bubble counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_pc4        = pc4_q;
  assign o_rs_data    = rs_data_q;
  assign o_rt_data    = rt_data_q;
  assign o_imm        = imm_q;
  assign o_rs         = rs_q;
  assign o_rt         = rt_q;
  assign o_rd         = rd_q;
  assign o_funct      = funct_q;
  assign o_ex_ctrl    = ex_ctrl_q;
  assign o_m_ctrl     = m_ctrl_q;
  assign o_wb_ctrl    = wb_ctrl_q;
  assign o_valid      = valid_q;
  assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_latch_id_ex.sv
// Directed bench for the ID/EX register: reset, load, bubble, hold, flush,
// combined squash and counter saturation (counter narrowed to 4 bits).
module tb_latch_id_ex;
  import latch_id_ex_pkg::*;

  localparam int NB_CNT = 4;

  logic        clk;
  logic        rst, enable, bubble, flush;
  logic [31:0] pc4, rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [3:0]  ex_ctrl;
  logic [2:0]  m_ctrl;
  logic [1:0]  wb_ctrl;
  logic [31:0] o_pc4, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [5:0]  o_funct;
  logic [3:0]  o_ex_ctrl;
  logic [2:0]  o_m_ctrl;
  logic [1:0]  o_wb_ctrl;
  logic        o_valid;
  logic [NB_CNT-1:0] o_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  latch_id_ex #(.NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_bubble(bubble), .i_flush(flush),
    .i_pc4(pc4), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_funct(funct),
    .i_ex_ctrl(ex_ctrl), .i_m_ctrl(m_ctrl), .i_wb_ctrl(wb_ctrl),
    .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_funct(o_funct),
    .o_ex_ctrl(o_ex_ctrl), .o_m_ctrl(o_m_ctrl), .o_wb_ctrl(o_wb_ctrl),
    .o_valid(o_valid), .o_bubble_cnt(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    pc4 = $urandom; rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    funct = 6'($urandom); ex_ctrl = 4'($urandom | 1);
    m_ctrl = 3'($urandom | 1); wb_ctrl = 2'($urandom | 1);
  endtask

  task automatic load_instr(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [5:0] f, input logic [3:0] ex,
                            input logic [2:0] m, input logic [1:0] wb);
    pc4 = p; rs_data = a; rt_data = b; imm = im; rs = s; rt = t; rd = d;
    funct = f; ex_ctrl = ex; m_ctrl = m; wb_ctrl = wb;
  endtask

  // every field zero, as after reset or a squash
  task automatic chk_nop(input string tag, input logic [31:0] cnt_exp);
    chk({tag, ".pc4"},     o_pc4,     32'h0);
    chk({tag, ".rs_data"}, o_rs_data, 32'h0);
    chk({tag, ".rt_data"}, o_rt_data, 32'h0);
    chk({tag, ".imm"},     o_imm,     32'h0);
    chk({tag, ".idx"},     {17'h0, o_rs, o_rt, o_rd}, 32'h0);
    chk({tag, ".funct"},   32'(o_funct),   32'h0);
    chk({tag, ".ex"},      32'(o_ex_ctrl), 32'h0);
    chk({tag, ".m"},       32'(o_m_ctrl),  32'h0);
    chk({tag, ".wb"},      32'(o_wb_ctrl), 32'h0);
    chk({tag, ".valid"},   32'(o_valid),   32'h0);
    chk({tag, ".cnt"},     32'(o_cnt),     cnt_exp);
  endtask

  // the ADD loaded after the bubble; also the frozen value during hold
  task automatic chk_add2(input string tag);
    chk({tag, ".pc4"},     o_pc4,          32'h0000_010C);
    chk({tag, ".rs_data"}, o_rs_data,      32'h0000_0011);
    chk({tag, ".rt_data"}, o_rt_data,      32'h0000_0022);
    chk({tag, ".rd"},      32'(o_rd),      32'h9);
    chk({tag, ".funct"},   32'(o_funct),   32'h20);
    chk({tag, ".ex"},      32'(o_ex_ctrl), 32'hA);
    chk({tag, ".wb"},      32'(o_wb_ctrl), 32'h2);
    chk({tag, ".valid"},   32'(o_valid),   32'h1);
    chk({tag, ".cnt"},     32'(o_cnt),     32'h1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; bubble = 1'b0; flush = 1'b0;
    rand_inputs();

    // reset with random inputs on the bus
    step();
    chk_nop("reset", 32'h0);

    // ADD $3,$1,$2 with rs=5, rt=7
    rst = 1'b0;
    load_instr(32'h104, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 6'h20, 4'b1010, 3'b000, 2'b10);
    step();
    chk("add.funct",   32'(o_funct),   32'h20);
    chk("add.ex",      32'(o_ex_ctrl), 32'hA);
    chk("add.rs_data", o_rs_data,      32'h5);
    chk("add.rt_data", o_rt_data,      32'h7);
    chk("add.idx",     {17'h0, o_rs, o_rt, o_rd}, {17'h0, 5'd1, 5'd2, 5'd3});
    chk("add.wb",      32'(o_wb_ctrl), 32'h2);
    chk("add.pc4",     o_pc4,          32'h104);
    chk("add.valid",   32'(o_valid),   32'h1);

    // LW $4, 8($1)
    load_instr(32'h108, 32'h5, 32'h0, 32'h8, 5'd1, 5'd4, 5'd0, 6'h08, 4'b0100, 3'b010, 2'b11);
    step();
    chk("lw.m",     32'(o_m_ctrl),  32'h2);
    chk("lw.ex",    32'(o_ex_ctrl), 32'h4);
    chk("lw.imm",   o_imm,          32'h8);
    chk("lw.wb",    32'(o_wb_ctrl), 32'h3);
    chk("lw.valid", 32'(o_valid),   32'h1);

    // dependent ADD in ID: load-use bubble for one cycle
    load_instr(32'h10C, 32'h11, 32'h22, 32'h0, 5'd4, 5'd5, 5'd9, 6'h20, 4'b1010, 3'b000, 2'b10);
    bubble = 1'b1;
    step();
    chk_nop("bubble", 32'h1);

    // same ID instruction reloads once the stall drops
    bubble = 1'b0;
    step();
    chk_add2("reload");

    // hold three edges with flush high and inputs changing
    enable = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bubble = i[0];
      step();
      chk_add2($sformatf("hold%0d", i));
    end

    // enable returns while flush still high: squash
    enable = 1'b1; bubble = 1'b0;
    rand_inputs();
    step();
    chk_nop("flush", 32'h2);

    // flush and bubble together count once
    flush = 1'b1; bubble = 1'b1;
    rand_inputs();
    step();
    chk_nop("both", 32'h3);

    // normal load afterwards
    flush = 1'b0; bubble = 1'b0;
    load_instr(32'h200, 32'hDEAD_BEEF, 32'h1, 32'h4, 5'd7, 5'd8, 5'd0, 6'h00, 4'b0100, 3'b001, 2'b00);
    step();
    chk("sw.rs_data", o_rs_data,     32'hDEAD_BEEF);
    chk("sw.m",       32'(o_m_ctrl), 32'h1);
    chk("sw.valid",   32'(o_valid),  32'h1);
    chk("sw.cnt",     32'(o_cnt),    32'h3);

    // saturation: 20 consecutive bubbles on a 4-bit counter
    rst = 1'b1;
    step();
    chk("sat.rst", 32'(o_cnt), 32'h0);
    rst = 1'b0; bubble = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      rand_inputs();
      step();
      chk($sformatf("sat%0d", i), 32'(o_cnt), (i < 15) ? i : 15);
    end
    chk("sat.valid", 32'(o_valid), 32'h0);

    // reset while bubbling clears the counter on the same edge
    rst = 1'b1;
    step();
    chk_nop("rst_mid", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
